if_id_stage_buf: RTL and testbench

Parametrised successor of the single-entry IF/ID pipeline register. It is a DEPTH-entry in-order buffer between fetch and decode, carrying {PC, PC+4, instruction} per entry. It replaces the bare stall/flush register with a valid/ready handshake, multi-entry decoupling and NOP presentation when empty. It also keeps a saturating bubble counter for performance monitoring.

---
 rtl/if_id_stage_buf.sv | 103 ++++++++++
 tb/tb_if_id_stage_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_buf.sv
// IF/ID decoupling buffer: DEPTH-entry in-order queue of {pc, pc+4, instr}
// with valid/ready on both sides, NOP presentation when empty and a bubble counter.
module if_id_stage_buf #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
    parameter int              BUB_W     = 16,
    localparam int             CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [XLEN-1:0]   in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pc_plus4,
    output logic [XLEN-1:0]   out_instr,
    output logic [CNT_W-1:0]  count,
    output logic [BUB_W-1:0]  bubble_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BUB_W-1:0]   bub_q, bub_d;
    logic               push, pop;
    entry_t             head;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready depends only on registered count; no path from out_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign head      = mem_q[rd_ptr_q];

    assign out_pc       = out_valid ? head.pc       : '0;
    assign out_pc_plus4 = out_valid ? head.pc_plus4 : '0;
    assign out_instr    = out_valid ? head.instr    : NOP_INSTR;
    assign count        = count_q;
    assign bubble_cnt   = bub_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bub_d    = bub_q;
        if (!out_valid && (bub_q != '1))
            bub_d = bub_q + BUB_W'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bub_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bub_q    <= bub_d;
        end
    end

    // Storage needs no reset: out_* are masked by count while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= '{pc: in_pc, pc_plus4: in_pc_plus4, instr: in_instr};
    end

endmodule

// File: tb/tb_if_id_stage_buf.sv
// Drives DEPTH=2 and DEPTH=3 buffers with shared stimulus and checks both
// every cycle against queue-based reference models.
module tb_if_id_stage_buf;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_flush = 1'b0, i_valid = 1'b0, o_ready = 1'b0;
    logic [31:0] i_pc = '0, i_p4 = '0, i_ins = '0;

    logic        ov [2];
    logic        ir [2];
    logic [31:0] opc [2], op4 [2], oin [2];
    logic [1:0]  cnt [2];
    logic [15:0] bub [2];

    int          n_chk = 0, n_bad = 0;
    int          dep [2] = '{2, 3};
    int          mb [2] = '{0, 0};
    logic [95:0] q0 [$];
    logic [95:0] q1 [$];
    logic [31:0] del [$];
    bit          seen200 = 0;

    always #5 clk = ~clk;

    if_id_stage_buf #(.DEPTH(2)) u_d2 (
        .clk(clk), .reset_n(reset_n), .flush(i_flush), .in_valid(i_valid), .in_ready(ir[0]),
        .in_pc(i_pc), .in_pc_plus4(i_p4), .in_instr(i_ins), .out_valid(ov[0]), .out_ready(o_ready),
        .out_pc(opc[0]), .out_pc_plus4(op4[0]), .out_instr(oin[0]), .count(cnt[0]), .bubble_cnt(bub[0]));

    if_id_stage_buf #(.DEPTH(3)) u_d3 (
        .clk(clk), .reset_n(reset_n), .flush(i_flush), .in_valid(i_valid), .in_ready(ir[1]),
        .in_pc(i_pc), .in_pc_plus4(i_p4), .in_instr(i_ins), .out_valid(ov[1]), .out_ready(o_ready),
        .out_pc(opc[1]), .out_pc_plus4(op4[1]), .out_instr(oin[1]), .count(cnt[1]), .bubble_cnt(bub[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [95:0] e;
        int sz;
        bit pu, po;
        e  = {i_pc, i_p4, i_ins};
        sz = q0.size();
        pu = i_valid && sz < 2 && !i_flush;
        po = sz > 0 && o_ready && !i_flush;
        if (sz == 0 && mb[0] < 65535) mb[0]++;
        if (i_flush) q0.delete();
        else begin
            if (po) void'(q0.pop_front());
            if (pu) q0.push_back(e);
        end
        sz = q1.size();
        pu = i_valid && sz < 3 && !i_flush;
        po = sz > 0 && o_ready && !i_flush;
        if (sz == 0 && mb[1] < 65535) mb[1]++;
        if (i_flush) q1.delete();
        else begin
            if (po) begin
                del.push_back(q1[0][95:64]);
                void'(q1.pop_front());
            end
            if (pu) q1.push_back(e);
        end
    endtask

    task automatic check_outs();
        logic [95:0] h;
        int sz;
        for (int k = 0; k < 2; k++) begin
            sz = (k == 0) ? q0.size() : q1.size();
            h  = (sz == 0) ? {32'h0, 32'h0, NOP} : ((k == 0) ? q0[0] : q1[0]);
            chk($sformatf("d%0d_valid", dep[k]), 64'(ov[k]),  64'(sz > 0));
            chk($sformatf("d%0d_ready", dep[k]), 64'(ir[k]),  64'(sz < dep[k]));
            chk($sformatf("d%0d_count", dep[k]), 64'(cnt[k]), 64'(sz));
            chk($sformatf("d%0d_pc",    dep[k]), 64'(opc[k]), 64'(h[95:64]));
            chk($sformatf("d%0d_pc4",   dep[k]), 64'(op4[k]), 64'(h[63:32]));
            chk($sformatf("d%0d_instr", dep[k]), 64'(oin[k]), 64'(h[31:0]));
            chk($sformatf("d%0d_bub",   dep[k]), 64'(bub[k]), 64'(mb[k]));
            if (ov[k] && opc[k] == 32'h200) seen200 = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins);
        i_valid = v;
        i_pc    = pc;
        i_p4    = pc + 32'd4;
        i_ins   = ins;
    endtask

    initial begin
        int guard;
        int nsent;
        #12 reset_n = 1'b1;
        #1 check_outs();

        // Idle after reset: five bubbles.
        for (int i = 0; i < 5; i++) step();
        chk("idle_bub5", 64'(bub[0]), 64'd5);
        chk("idle_nop", 64'(oin[0]), 64'(NOP));

        // Single push, visible one cycle later, then consumed.
        o_ready = 1'b1;
        drive(1, 32'h100, 32'h00500093);
        step();
        drive(0, 0, 0);
        chk("single_pc", 64'(opc[0]), 64'h100);
        chk("single_instr", 64'(oin[0]), 64'h00500093);
        step();
        chk("single_gone", 64'(ov[0]), 64'd0);

        // Decode stall: fill DEPTH=2, third entry refused until space frees.
        o_ready = 1'b0;
        drive(1, 32'h100, 32'h11);
        step();
        drive(1, 32'h104, 32'h22);
        step();
        chk("full_ready", 64'(ir[0]), 64'd0);
        drive(1, 32'h108, 32'h33);
        step();
        step();
        chk("stall_hold_pc", 64'(opc[0]), 64'h100);
        o_ready = 1'b1;
        guard = 0;
        while (!ir[0] && guard < 20) begin step(); guard++; end
        step();
        drive(0, 0, 0);
        for (int i = 0; i < 4; i++) step();

        // Flush while full drops buffered entries and the same-cycle push.
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin drive(1, 32'h180 + 32'(4 * i), 32'h44); step(); end
        drive(1, 32'h200, 32'h55);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        drive(0, 0, 0);
        chk("flush_cnt", 64'(cnt[0]), 64'd0);
        chk("flush_nop", 64'(oin[1]), 64'(NOP));
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("no_0x200", 64'(seen200), 64'd0);

        // DEPTH=3 streaming with out_ready toggling 1,0,1,0.
        del.delete();
        nsent = 0;
        guard = 0;
        while (nsent < 10 && guard < 100) begin
            bit acc;
            o_ready = (guard % 2 == 0);
            drive(1, 32'h300 + 32'(4 * nsent), 32'h1000 + 32'(nsent));
            acc = ir[1];
            step();
            if (acc) nsent++;
            guard++;
        end
        drive(0, 0, 0);
        o_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("stream_len", 64'(del.size()), 64'd10);
        for (int i = 0; i < 10 && i < del.size(); i++)
            chk($sformatf("stream_pc%0d", i), 64'(del[i]), 64'(32'h300 + 32'(4 * i)));

        // Random traffic with a mid-cycle asynchronous reset.
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) < 7, {$urandom_range(16'h400, 16'hffff), 2'b00},
                  $urandom);
            o_ready = $urandom_range(0, 9) < 6;
            i_flush = $urandom_range(0, 19) == 0;
            if (c == 300) begin
                @(posedge clk);
                model_edge();
                #3 reset_n = 1'b0;
                #1;
                for (int k = 0; k < 2; k++) begin
                    chk("arst_valid", 64'(ov[k]), 64'd0);
                    chk("arst_count", 64'(cnt[k]), 64'd0);
                    chk("arst_bub", 64'(bub[k]), 64'd0);
                    chk("arst_instr", 64'(oin[k]), 64'(NOP));
                    chk("arst_pc", 64'(opc[k]), 64'd0);
                    chk("arst_ready", 64'(ir[k]), 64'd1);
                end
                q0.delete();
                q1.delete();
                mb[0] = 0;
                mb[1] = 0;
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
